// File: rtl/rv_pkg.sv
// Shared CPU package: base opcodes, the immediate-format enumeration and
// the opcode-to-format decode used by the immediate generator.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: decodes the format from the opcode and assembles the
// sign-extended immediate. Unknown opcodes yield 0.
// Ports:
//   inst  in  32    instruction word
//   imm   out XLEN  sign-extended immediate (inst[31] replicated)
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    imm_type_e   imm_type;
    logic [31:0] imm_raw;

    always_comb begin
        imm_type = imm_type_of(inst[6:0]);
        imm_raw  = '0;
        case (imm_type)
            IMM_I: imm_raw = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm_raw = {inst[31:12], 12'b0};
            IMM_J: imm_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm_raw = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_ext
            assign imm = {{(XLEN-32){imm_raw[31]}}, imm_raw};
        end else begin : g_trunc
            assign imm = imm_raw[XLEN-1:0];
        end
    endgenerate

endmodule

// File: rtl/rv_regfile_sb.sv
// Register file with write-first bypass plus a load/IO scoreboard.
// Ports:
//   clk, rst (async, active-low)
//   rd_addr/rd_data   NRD packed combinational read ports (x0 reads 0)
//   wr_en/wr_addr/wr_sel/alu_result/mem_data   write-back (wr_sel=1 -> mem_data)
//   issue_en/issue_rd long-latency issue, marks destination pending
//   pending           per-register outstanding-result bits
//   stall             some read port sees an unresolved pending register
//   inst/imm32        immediate generation
module rv_regfile_sb
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NRD      = 2,
    parameter int              INIT_IDX = 31,
    parameter logic [XLEN-1:0] INIT_VAL = 32'hFFFFFC00,
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                wr_sel,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     mem_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREGS-1:0]    pending,
    output logic                stall,
    input  logic [31:0]         inst,
    output logic [XLEN-1:0]     imm32
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NRD-1:0]   busy_vec;
    logic [XLEN-1:0]  wdata;
    logic             wr_ok;
    logic             wr_hit;
    logic             clr_hit;

    assign wdata   = wr_sel ? mem_data : alu_result;
    // Addresses beyond NREGS exist only for non-power-of-two NREGS.
    assign wr_ok   = ({1'b0, wr_addr} < NREGS_W);
    assign wr_hit  = wr_en && wr_ok && (wr_addr != '0);
    assign clr_hit = wr_en && wr_sel && wr_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
            end
        end else if (wr_hit) begin
            regs_reg[wr_addr] <= wdata;
        end
    end

    // Per-register set/clear decode; x0 can never become pending.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
            end else begin : g_nz
                assign set_vec[gi] = issue_en && (issue_rd == AW'(gi));
            end
            assign clr_vec[gi] = clr_hit && (wr_addr == AW'(gi));
        end
    endgenerate

    // Set applied after clear so a same-cycle re-issue keeps the bit set.
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic            ra_ok;
            logic            ra_bypass;
            logic [XLEN-1:0] rd_word;

            assign ra        = rd_addr[gi*AW +: AW];
            assign ra_ok     = ({1'b0, ra} < NREGS_W) && (ra != '0);
            assign ra_bypass = wr_hit && (wr_addr == ra);

            always_comb begin
                rd_word = '0;
                if (rst && ra_ok) begin
                    rd_word = ra_bypass ? wdata : regs_reg[ra];
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = rd_word;
            // A load write-back in this very cycle resolves the hazard.
            assign busy_vec[gi] = rst && ra_ok && pending_reg[ra]
                                  && !(clr_hit && (wr_addr == ra));
        end
    endgenerate

    assign stall = |busy_vec;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .imm  (imm32)
    );

endmodule
